// File: rtl/cpu_types_pkg.sv
// Shared CPU types: multiply/divide opcode encoding and default datapath width.
package cpu_types_pkg;

  localparam int MDU_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_t;

  function automatic logic op_is_div(input mdu_op_t o);
    return (o == MDU_DIV) || (o == MDU_DIVU);
  endfunction

  function automatic logic op_is_signed(input mdu_op_t o);
    return (o == MDU_MULT) || (o == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Bundle of the multiply/divide unit's pins, organised like the ALU interface.
interface mdu_if #(
  parameter int WIDTH = cpu_types_pkg::MDU_WIDTH_DEFAULT
) (
  input logic CLK
);
  logic                  nRST;
  logic                  start;
  cpu_types_pkg::mdu_op_t op;
  logic [WIDTH-1:0]      port_a;
  logic [WIDTH-1:0]      port_b;
  logic                  wr_hi;
  logic                  wr_lo;
  logic [WIDTH-1:0]      wdata;
  logic                  busy;
  logic                  done;
  logic                  div_zero;
  logic [WIDTH-1:0]      hi;
  logic [WIDTH-1:0]      lo;

  modport mdu (
    input  CLK, nRST, start, op, port_a, port_b, wr_hi, wr_lo, wdata,
    output busy, done, div_zero, hi, lo
  );

  modport tb (
    input  CLK, busy, done, div_zero, hi, lo,
    output nRST, start, op, port_a, port_b, wr_hi, wr_lo, wdata
  );
endinterface

// File: rtl/mdu_shift_core.sv
// Radix-2 datapath: one shift-add (multiply) or restoring shift-subtract
// (divide) step per cycle on a 2*WIDTH accumulator, plus the step counter.
module mdu_shift_core #(
  parameter int WIDTH = 32
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic [2*WIDTH-1:0] acc,
  output logic               last
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   addend;
  logic               div_q, div_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;

  assign acc  = acc_q;
  assign last = (cnt_q == CNT_LAST);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    cnt_d  = cnt_q;

    // Multiply: low half holds the multiplier, its LSB gates the add into the high half.
    addend    = acc_q[0] ? opnd_q : {WIDTH{1'b0}};
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    // Divide: partial remainder shifted left with the next dividend bit, minus divisor.
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};

    if (load) begin
      acc_d  = {{WIDTH{1'b0}}, a_mag};
      opnd_d = b_mag;
      div_d  = is_div;
      cnt_d  = '0;
    end else if (step) begin
      cnt_d = last ? '0 : cnt_q + CW'(1);
      if (!div_q) begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end else if (!div_trial[WIDTH]) begin
        acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO pair:
// FSM, sign handling, result fix-up and direct-write arbitration.
module mul_div_unit
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  mdu_op_t          op,
  input  logic [WIDTH-1:0] port_a,
  input  logic [WIDTH-1:0] port_b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  mdu_op_t            op_q, op_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               accept;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] core_acc;
  logic               core_last;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign busy     = (state_q == S_CALC) || (state_q == S_FIX);
  assign done     = (state_q == S_DONE);
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign sign_a = op_is_signed(op) && port_a[WIDTH-1];
  assign sign_b = op_is_signed(op) && port_b[WIDTH-1];
  assign a_mag  = sign_a ? -port_a : port_a;
  assign b_mag  = sign_b ? -port_b : port_b;

  mdu_shift_core #(.WIDTH(WIDTH)) u_core (
    .CLK    (CLK),
    .nRST   (nRST),
    .load   (accept),
    .step   (state_q == S_CALC),
    .is_div (op_is_div(op)),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .acc    (core_acc),
    .last   (core_last)
  );

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign prod_fix = (neg_a_q ^ neg_b_q) ? -core_acc : core_acc;
  assign quot_fix = (neg_a_q ^ neg_b_q) ? -core_acc[WIDTH-1:0] : core_acc[WIDTH-1:0];
  assign rem_fix  = neg_a_q ? -core_acc[2*WIDTH-1:WIDTH] : core_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_raw_d = a_raw_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE, S_DONE: state_d = accept ? S_CALC : S_IDLE;
      S_CALC:         state_d = core_last ? S_FIX : S_CALC;
      S_FIX:          state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase

    if (accept) begin
      op_d    = op;
      a_raw_d = port_a;
      neg_a_d = sign_a;
      neg_b_d = sign_b;
      dz_d    = op_is_div(op) && (port_b == '0);
    end

    // The FIX cycle owns HI/LO; direct writes only land when idle and not starting.
    if (state_q == S_FIX) begin
      if (!op_is_div(op_q)) begin
        {hi_d, lo_d} = prod_fix;
      end else if (dz_q) begin
        hi_d = a_raw_q;
        lo_d = '1;
      end else begin
        hi_d = rem_fix;
        lo_d = quot_fix;
      end
    end else if (!busy && !start) begin
      if (wr_hi) hi_d = wdata;
      if (wr_lo) lo_d = wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      op_q    <= MDU_MULT;
      a_raw_q <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_raw_q <= a_raw_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corners, handshake cases,
// randomized operations against an arithmetic reference model, mid-op reset.
module tb_mul_div_unit;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        nRST;
  logic        start;
  mdu_op_t     op;
  logic [31:0] port_a;
  logic [31:0] port_b;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .start    (start),
    .op       (op),
    .port_a   (port_a),
    .port_b   (port_b),
    .wr_hi    (wr_hi),
    .wr_lo    (wr_lo),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain arithmetic on the operands, including the zero-divisor rule.
  task automatic model(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output logic ez);
    longint      sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ez = 1'b0;
    eh = '0;
    el = '0;
    case (o)
      MDU_MULT:  begin p = sa * sb; {eh, el} = p; end
      MDU_MULTU: begin up = {32'd0, a} * {32'd0, b}; {eh, el} = up; end
      MDU_DIV, MDU_DIVU: begin
        if (b == 32'd0) begin
          eh = a; el = 32'hFFFF_FFFF; ez = 1'b1;
        end else if (o == MDU_DIV) begin
          q = sa / sb; r = sa % sb;
          el = q[31:0]; eh = r[31:0];
        end else begin
          el = a / b; eh = a % b;
        end
      end
      default: ;
    endcase
  endtask

  // Launch one op (optionally in the current cycle, optionally with a colliding wr_hi),
  // then check latency, busy span, HI/LO stability and the result.
  task automatic run_op(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b,
                        input logic imm, input logic wr_too, input string tag);
    logic [31:0] eh, el, h0, l0;
    logic        ez;
    int          lat, busy_cnt, moved;
    model(o, a, b, eh, el, ez);
    if (!imm) @(negedge CLK);
    start = 1'b1; op = o; port_a = a; port_b = b;
    if (wr_too) begin wr_hi = 1'b1; wdata = 32'hBEEF; end
    @(negedge CLK);
    start = 1'b0; wr_hi = 1'b0;
    h0 = hi; l0 = lo;
    lat = 1; busy_cnt = 0; moved = 0;
    while (!done && lat < 200) begin
      if (busy) busy_cnt++;
      if (hi !== h0 || lo !== l0) moved++;
      @(negedge CLK);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd34);
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({tag, " hilo_stable"}, 64'(moved), 64'd0);
    check({tag, " hi"}, {32'd0, hi}, {32'd0, eh});
    check({tag, " lo"}, {32'd0, lo}, {32'd0, el});
    check({tag, " div_zero"}, {63'd0, div_zero}, {63'd0, ez});
  endtask

  initial begin
    int          lat, dcount;
    logic [31:0] ra, rb;
    mdu_op_t     ro;

    nRST = 1'b0; start = 1'b0; op = MDU_MULT; port_a = '0; port_b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
    repeat (2) @(negedge CLK);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset div_zero", {63'd0, div_zero}, 64'd0);
    check("reset hi", {32'd0, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);
    nRST = 1'b1;

    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "multu_max");
    run_op(MDU_MULT,  -32'd3,        32'd7,         1'b0, 1'b0, "mult_neg3x7");
    run_op(MDU_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, "mult_minxmin");
    run_op(MDU_DIV,   -32'd7,        32'd2,         1'b0, 1'b0, "div_neg7by2");
    run_op(MDU_DIVU,  32'd100,       32'd7,         1'b0, 1'b0, "divu_100by7");
    run_op(MDU_DIVU,  32'h1234,      32'd0,         1'b0, 1'b0, "divu_by0");
    run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_overflow");

    // Start in cycle 5 and wr_hi in cycle 7 of a busy op must both be ignored.
    @(negedge CLK);
    start = 1'b1; op = MDU_MULTU; port_a = 32'd3; port_b = 32'd5;
    @(negedge CLK);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      if (lat == 5) begin start = 1'b1; op = MDU_DIVU; port_a = 32'd99; port_b = 32'd0; end
      else start = 1'b0;
      if (lat == 7) begin wr_hi = 1'b1; wdata = 32'hAAAA; end
      else wr_hi = 1'b0;
      @(negedge CLK);
      lat++;
    end
    start = 1'b0; wr_hi = 1'b0;
    check("ignore_start latency", 64'(lat), 64'd34);
    check("ignore_start hi", {32'd0, hi}, 64'd0);
    check("ignore_start lo", {32'd0, lo}, 64'd15);
    check("ignore_start div_zero", {63'd0, div_zero}, 64'd0);

    // Idle direct write to LO only.
    @(negedge CLK);
    wr_lo = 1'b1; wdata = 32'h5555;
    @(negedge CLK);
    wr_lo = 1'b0;
    check("wr_lo idle lo", {32'd0, lo}, 64'h5555);
    check("wr_lo idle hi", {32'd0, hi}, 64'd0);

    // Collision: start wins, wr_hi is dropped; then a back-to-back start in DONE.
    run_op(MDU_MULTU, 32'd2, 32'd2, 1'b0, 1'b1, "start_vs_wr");
    run_op(MDU_DIV,   32'd50, -32'd6, 1'b1, 1'b0, "back_to_back");

    for (int i = 0; i < 12; i++) begin
      ro = mdu_op_t'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = -$urandom_range(1, 20);
        2:       rb = $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, 1'b0, 1'b0, $sformatf("rand%0d", i));
    end

    // Make HI/LO nonzero, then abort a MULTU with reset in cycle 10.
    @(negedge CLK);
    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hC0DE;
    @(negedge CLK);
    wr_hi = 1'b0; wr_lo = 1'b0;
    start = 1'b1; op = MDU_MULTU; port_a = 32'hFFFF_FFFF; port_b = 32'hFFFF_FFFF;
    @(negedge CLK);
    start = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    check("midreset busy", {63'd0, busy}, 64'd0);
    check("midreset done", {63'd0, done}, 64'd0);
    check("midreset div_zero", {63'd0, div_zero}, 64'd0);
    check("midreset hi", {32'd0, hi}, 64'd0);
    check("midreset lo", {32'd0, lo}, 64'd0);
    dcount = 0;
    for (int c = 0; c < 40; c++) begin
      if (done || busy) dcount++;
      @(negedge CLK);
    end
    check("midreset no_done", 64'(dcount), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
